// File: rtl/wallace_multiplier.sv
// Unsigned 4x4 multiplier: two-stage Wallace tree of half/full adders plus a ripple-carry
// final adder, with a registered 8-bit product and a one-cycle valid strobe.

module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic co
);
   assign s  = a ^ b;
   assign co = a & b;
endmodule

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module wallace_multiplier (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic [7:0] products,
   output logic       out_valid
);
   // pp[i][j] carries weight i+j
   logic [3:0] pp [4];

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            pp[i][j] = A[i] & B[j];
         end
      end
   end

   // Stage 1: column heights 1,2,3,4,3,2,1 -> 1,1,2,3,2,2,2
   logic s1_1, s1_2, s1_3, s1_4, s1_5;
   logic k1_2, k1_3, k1_4, k1_5, k1_6;

   half_adder ha_1_1 (.a(pp[1][0]), .b(pp[0][1]), .s(s1_1), .co(k1_2));
   full_adder fa_1_2 (.a(pp[2][0]), .b(pp[1][1]), .ci(pp[0][2]), .s(s1_2), .co(k1_3));
   full_adder fa_1_3 (.a(pp[3][0]), .b(pp[2][1]), .ci(pp[1][2]), .s(s1_3), .co(k1_4));
   full_adder fa_1_4 (.a(pp[3][1]), .b(pp[2][2]), .ci(pp[1][3]), .s(s1_4), .co(k1_5));
   half_adder ha_1_5 (.a(pp[3][2]), .b(pp[2][3]), .s(s1_5), .co(k1_6));

   // Stage 2: every pair or triple is reduced, leaving two rows over columns 3..6 and one bit in column 7
   logic s2_2, s2_3, s2_4, s2_5, s2_6;
   logic k2_3, k2_4, k2_5, k2_6, k2_7;

   half_adder ha_2_2 (.a(s1_2), .b(k1_2), .s(s2_2), .co(k2_3));
   full_adder fa_2_3 (.a(s1_3), .b(pp[0][3]), .ci(k1_3), .s(s2_3), .co(k2_4));
   half_adder ha_2_4 (.a(s1_4), .b(k1_4), .s(s2_4), .co(k2_5));
   half_adder ha_2_5 (.a(s1_5), .b(k1_5), .s(s2_5), .co(k2_6));
   half_adder ha_2_6 (.a(pp[3][3]), .b(k1_6), .s(s2_6), .co(k2_7));

   // Final ripple-carry adder over the two remaining rows
   logic r3, r4, r5, r6;
   logic cy4, cy5, cy6, cy7;

   half_adder ha_f_3 (.a(s2_3), .b(k2_3), .s(r3), .co(cy4));
   full_adder fa_f_4 (.a(s2_4), .b(k2_4), .ci(cy4), .s(r4), .co(cy5));
   full_adder fa_f_5 (.a(s2_5), .b(k2_5), .ci(cy5), .s(r5), .co(cy6));
   full_adder fa_f_6 (.a(s2_6), .b(k2_6), .ci(cy6), .s(r6), .co(cy7));

   // Product never exceeds 225, so cy7 and k2_7 are never both set
   logic [7:0] prod_comb;
   assign prod_comb = {cy7 ^ k2_7, r6, r5, r4, r3, s2_2, s1_1, pp[0][0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         products  <= 8'd0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            products <= prod_comb;
         end
      end
   end
endmodule

// File: tb/tb_wallace_multiplier.sv
// Randomised bench for wallace_multiplier against an arithmetic reference model
// (product = A*B, held while idle, cleared by reset).

module tb_wallace_multiplier;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] A = 4'd0;
   logic [3:0] B = 4'd0;
   logic [7:0] products;
   logic       out_valid;

   int checks = 0;
   int failures = 0;
   int m_prod = 0;
   int m_vld = 0;

   wallace_multiplier dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .A(A),
      .B(B),
      .products(products),
      .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: drive on the falling edge, update model, compare 1ns after the rising edge
   task automatic cyc(input string tag, input logic r, input logic v,
                      input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      rst = r;
      in_valid = v;
      A = a;
      B = b;
      @(posedge clk);
      #1;
      if (r) begin
         m_prod = 0;
         m_vld = 0;
      end else begin
         m_vld = int'(v);
         if (v) m_prod = int'(a) * int'(b);
      end
      check({tag, ".products"}, int'(products), m_prod);
      check({tag, ".out_valid"}, int'(out_valid), m_vld);
   endtask

   function automatic logic [3:0] rnd4();
      return 4'($urandom_range(0, 15));
   endfunction

   initial begin
      // Reset held for two clocks, then released with nothing issued
      cyc("reset0", 1'b1, 1'b0, 4'd0, 4'd0);
      cyc("reset1", 1'b1, 1'b0, 4'd0, 4'd0);
      cyc("post_reset", 1'b0, 1'b0, rnd4(), rnd4());
      check("reset_products", int'(products), 0);

      // Basic 10*3 then hold
      cyc("ten_by_three", 1'b0, 1'b1, 4'd10, 4'd3);
      check("ten_by_three_lit", int'(products), 30);
      cyc("hold30", 1'b0, 1'b0, rnd4(), rnd4());
      check("hold30_lit", int'(products), 30);

      // Corners
      cyc("c15x15", 1'b0, 1'b1, 4'd15, 4'd15);
      check("c15x15_lit", int'(products), 225);
      cyc("c0x9", 1'b0, 1'b1, 4'd0, 4'd9);
      cyc("c1x13", 1'b0, 1'b1, 4'd1, 4'd13);
      check("c1x13_lit", int'(products), 13);
      cyc("c8x8", 1'b0, 1'b1, 4'd8, 4'd8);
      check("c8x8_lit", int'(products), 64);

      // Back-to-back issue
      cyc("b2b_3x5", 1'b0, 1'b1, 4'd3, 4'd5);
      cyc("b2b_7x6", 1'b0, 1'b1, 4'd7, 4'd6);
      cyc("b2b_12x11", 1'b0, 1'b1, 4'd12, 4'd11);
      check("b2b_12x11_lit", int'(products), 132);

      // Reset wins over a simultaneous valid; 81 must never appear
      cyc("rst_vs_valid", 1'b1, 1'b1, 4'd9, 4'd9);
      cyc("after_rst", 1'b0, 1'b0, 4'd9, 4'd9);
      check("after_rst_lit", int'(products), 0);

      // Full sweep with random idle gaps carrying random operand noise
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
               cyc("sweep_gap", 1'b0, 1'b0, rnd4(), rnd4());
            end
            cyc("sweep", 1'b0, 1'b1, 4'(a), 4'(b));
         end
      end
      cyc("sweep_tail", 1'b0, 1'b0, rnd4(), rnd4());

      // Random mix including occasional mid-stream reset
      for (int n = 0; n < 300; n++) begin
         cyc("random", ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), rnd4(), rnd4());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
